// File: rtl/skew_loader_if.sv
// ---------------------------------------------------------------------------
// skew_loader_if
//   Bundles the operand stream, tile control and SRAM write port of one
//   skew_loader instance.
//   master : upstream feeder / sequencer side (drives i_*, observes o_*)
//   slave  : the skew_loader itself (observes i_*, drives o_*)
//   Signals:
//     i_start, i_base_addr, i_num_vec : tile start and its latched arguments
//     i_vld, o_rdy, i_data            : operand vector stream
//     o_wr_en, o_wr_addr, o_wr_data   : SRAM bank write port
//     o_busy, o_done, o_stall_cnt     : status
// ---------------------------------------------------------------------------
interface skew_loader_if #(
  parameter int NUM_LANES            = 4,
  parameter int DATA_WIDTH           = 8,
  parameter int LOG2_SRAM_BANK_DEPTH = 5
);
  logic                              i_start;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]   i_base_addr;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]   i_num_vec;
  logic                              i_vld;
  logic                              o_rdy;
  logic [NUM_LANES*DATA_WIDTH-1:0]   i_data;
  logic                              o_wr_en;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]   o_wr_addr;
  logic [NUM_LANES*DATA_WIDTH-1:0]   o_wr_data;
  logic                              o_busy;
  logic                              o_done;
  logic [15:0]                       o_stall_cnt;

  modport master (
    output i_start, i_base_addr, i_num_vec, i_vld, i_data,
    input  o_rdy, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_stall_cnt
  );

  modport slave (
    input  i_start, i_base_addr, i_num_vec, i_vld, i_data,
    output o_rdy, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_stall_cnt
  );
endinterface

// File: rtl/skew_loader.sv
// ---------------------------------------------------------------------------
// skew_loader
//   Takes K unskewed operand vectors over a valid/ready stream and writes
//   K+NUM_LANES-1 diagonally skewed wavefronts into one systolic-array operand
//   SRAM bank. Lane j is delayed by j vectors; empty slots are zero, so the
//   GEMM sequencer can read the bank linearly.
//   Ports:
//     clk  : clock, all logic on posedge
//     rst  : synchronous active-high reset (aborts any load in progress)
//     bus  : skew_loader_if.slave (stream in, SRAM write port and status out)
//   Optional feature:
//     SKEW_LOADER_STALL_CNT_EN - when defined, o_stall_cnt counts LOAD cycles
//     with i_vld low (saturating); otherwise o_stall_cnt is tied to zero.
// ---------------------------------------------------------------------------
module skew_loader #(
  parameter int NUM_LANES            = 4,
  parameter int DATA_WIDTH           = 8,
  parameter int LOG2_SRAM_BANK_DEPTH = 5
) (
  input  logic           clk,
  input  logic           rst,
  skew_loader_if.slave   bus
);

  localparam int AW = LOG2_SRAM_BANK_DEPTH;
  localparam int FW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'((NUM_LANES > 1) ? NUM_LANES - 2 : 0);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t                          state;
  logic [AW-1:0]                   addr_ptr;
  logic [AW-1:0]                   num_vec;
  logic [AW-1:0]                   vec_cnt;
  logic [FW-1:0]                   flush_cnt;
  logic                            wr_en;
  logic [AW-1:0]                   wr_addr;
  logic [NUM_LANES*DATA_WIDTH-1:0] wr_data;
  logic                            done;

  logic                            accept;
  logic                            step;
  logic                            start_acc;
  logic [DATA_WIDTH-1:0]           lane_in  [NUM_LANES];
  logic [DATA_WIDTH-1:0]           lane_tap [NUM_LANES];
  logic [NUM_LANES*DATA_WIDTH-1:0] wave;

  assign accept    = bus.i_vld && (state == LOAD);
  // Every accepted vector and every FLUSH cycle produces exactly one wavefront.
  assign step      = accept || (state == FLUSH);
  // The cycle o_done is high the FSM is already back in IDLE; a start there
  // would overlap the done pulse, so it is held off for that one cycle.
  assign start_acc = (state == IDLE) && bus.i_start && !done;

  assign bus.o_rdy     = (state == LOAD);
  assign bus.o_busy    = (state != IDLE);
  assign bus.o_wr_en   = wr_en;
  assign bus.o_wr_addr = wr_addr;
  assign bus.o_wr_data = wr_data;
  assign bus.o_done    = done;

  // Lane j taps the value shifted in j steps ago; lane 0 passes straight through.
  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    assign lane_in[j] = accept ? bus.i_data[j*DATA_WIDTH +: DATA_WIDTH] : '0;

    if (j == 0) begin : g_direct
      assign lane_tap[j] = lane_in[j];
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] sr [j];

      // NOTE: these shift registers are reset (and cleared on start) on
      // purpose: their contents become the zero padding of the first
      // wavefronts, so a plain uninitialised RAM-style array would be wrong.
      always_ff @(posedge clk) begin
        if (rst || start_acc) begin
          for (int k = 0; k < j; k++) sr[k] <= '0;
        end else if (step) begin
          sr[0] <= lane_in[j];
          for (int k = 1; k < j; k++) sr[k] <= sr[k-1];
        end
      end

      assign lane_tap[j] = sr[j-1];
    end
  end

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    wave = '0;
    for (int j = 0; j < NUM_LANES; j++) wave[j*DATA_WIDTH +: DATA_WIDTH] = lane_tap[j];
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_ptr  <= '0;
      num_vec   <= '0;
      vec_cnt   <= '0;
      flush_cnt <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      done      <= 1'b0;
    end else begin
      wr_en <= step;
      done  <= (state == DONE);

      // Write data and address only move on a step; they hold otherwise.
      if (step) begin
        wr_addr  <= addr_ptr;
        addr_ptr <= addr_ptr + 1'b1;
        wr_data  <= wave;
      end

      unique case (state)
        IDLE: begin
          if (start_acc) begin
            addr_ptr  <= bus.i_base_addr;
            num_vec   <= bus.i_num_vec;
            vec_cnt   <= '0;
            flush_cnt <= '0;
            state     <= (bus.i_num_vec == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            vec_cnt <= vec_cnt + 1'b1;
            if (vec_cnt == num_vec - 1'b1) state <= (NUM_LANES == 1) ? DONE : FLUSH;
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt + 1'b1;
          if (flush_cnt == FLUSH_LAST) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SKEW_LOADER_STALL_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      stall_cnt <= '0;
    end else if ((state == LOAD) && !bus.i_vld && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign bus.o_stall_cnt = stall_cnt;
`else
  assign bus.o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_skew_loader.sv
// ---------------------------------------------------------------------------
// tb_skew_loader
//   Directed bench for skew_loader (NUM_LANES=4, DATA_WIDTH=8, depth 2^5).
//   Vector t carries lane j = 4t+j+1. A negedge monitor logs every write and
//   done pulse with its cycle number; each scenario compares the log against
//   a hand-computed table of {address, wavefront} records.
// ---------------------------------------------------------------------------
module tb_skew_loader;

  localparam int NL = 4;
  localparam int DW = 8;
  localparam int AW = 5;

`ifdef SKEW_LOADER_STALL_CNT_EN
  localparam logic [15:0] STALL_EXP = 16'd3;
`else
  localparam logic [15:0] STALL_EXP = 16'd0;
`endif

  typedef struct {
    logic [AW-1:0]    addr;
    logic [NL*DW-1:0] wave;
  } wr_exp_t;

  typedef struct {
    logic [AW-1:0]    addr;
    logic [NL*DW-1:0] wave;
    int               cyc;
  } wr_rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  skew_loader_if #(.NUM_LANES(NL), .DATA_WIDTH(DW), .LOG2_SRAM_BANK_DEPTH(AW)) bus ();

  skew_loader #(.NUM_LANES(NL), .DATA_WIDTH(DW), .LOG2_SRAM_BANK_DEPTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wr_rec_t wr_log[$];
  int      done_log[$];
  int      rdy_cnt = 0;

  always @(negedge clk) begin
    wr_rec_t r;
    if (bus.o_wr_en) begin
      r.addr = bus.o_wr_addr;
      r.wave = bus.o_wr_data;
      r.cyc  = cyc;
      wr_log.push_back(r);
    end
    if (bus.o_done) done_log.push_back(cyc);
    if (bus.o_rdy)  rdy_cnt++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NL*DW-1:0] vec_data(input int t);
    logic [NL*DW-1:0] v;
    for (int j = 0; j < NL; j++) v[j*DW +: DW] = DW'(4*t + j + 1);
    return v;
  endfunction

  task automatic clear_logs();
    wr_log.delete();
    done_log.delete();
    rdy_cnt = 0;
  endtask

  // All tasks enter and leave #1 after a posedge.
  task automatic start_tile(input logic [AW-1:0] base, input logic [AW-1:0] k, output int start_cyc);
    bus.i_start     = 1'b1;
    bus.i_base_addr = base;
    bus.i_num_vec   = k;
    @(posedge clk); #1;
    start_cyc       = cyc;
    bus.i_start     = 1'b0;
    bus.i_base_addr = 5'd17;
    bus.i_num_vec   = 5'd9;
  endtask

  task automatic send_vec(input int t);
    int n = 0;
    bit acc = 1'b0;
    bus.i_vld  = 1'b1;
    bus.i_data = vec_data(t);
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = bus.o_rdy;
      @(posedge clk); #1;
      n++;
    end
    bus.i_vld  = 1'b0;
    bus.i_data = '1;
    check($sformatf("send_vec%0d_accepted", t), 32'(acc), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!bus.o_done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(bus.o_done), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic compare_writes(input string tag, input wr_exp_t exp[7], input int n,
                                input int gap_at, input int gap);
    int m;
    check({tag, "_write_count"}, 32'(wr_log.size()), 32'(n));
    m = (wr_log.size() < n) ? wr_log.size() : n;
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(wr_log[i].addr), 32'(exp[i].addr));
      check($sformatf("%s_wave%0d", tag, i), wr_log[i].wave, exp[i].wave);
      if (i > 0)
        check($sformatf("%s_spacing%0d", tag, i), 32'(wr_log[i].cyc - wr_log[i-1].cyc),
              (i == gap_at) ? 32'(gap + 1) : 32'd1);
    end
    check({tag, "_done_pulses"}, 32'(done_log.size()), 32'd1);
    if (done_log.size() > 0 && m > 0)
      check({tag, "_done_timing"}, 32'(done_log[0]), 32'(wr_log[m-1].cyc + 1));
  endtask

  initial begin
    wr_exp_t t1_exp[7];
    wr_exp_t t3_exp[7];
    wr_exp_t t4_exp[7];
    wr_exp_t t5_exp[7];
    wr_exp_t t6_exp[7];
    logic [NL*DW-1:0] w4[7];
    logic [NL*DW-1:0] w2[7];
    int sc;
    int n;

    // Wavefronts for K=4 (lanes 3..0 packed high to low).
    w4 = '{32'h00000001, 32'h00000205, 32'h00030609, 32'h04070A0D,
           32'h080B0E00, 32'h0C0F0000, 32'h10000000};
    // Wavefronts for K=2; the last two slots are unused.
    w2 = '{32'h00000001, 32'h00000205, 32'h00030600, 32'h04070000,
           32'h08000000, 32'h0, 32'h0};
    for (int i = 0; i < 7; i++) begin
      t1_exp[i] = '{addr: AW'(1 + i),                wave: w4[i]};
      t3_exp[i] = '{addr: AW'((30 + i) % 32),        wave: w4[i]};
      t4_exp[i] = '{addr: AW'(2 + i),                wave: w2[i]};
      t6_exp[i] = '{addr: AW'(8 + i),                wave: w2[i]};
      t5_exp[i] = '{addr: AW'(i),                    wave: 32'h0};
    end
    // K=1: only vector 0 ({4,3,2,1}) walks across the lanes.
    t5_exp[0].wave = 32'h00000001;
    t5_exp[1].wave = 32'h00000200;
    t5_exp[2].wave = 32'h00030000;
    t5_exp[3].wave = 32'h04000000;

    bus.i_start     = 1'b0;
    bus.i_base_addr = '0;
    bus.i_num_vec   = '0;
    bus.i_vld       = 1'b0;
    bus.i_data      = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_wr_en",   32'(bus.o_wr_en),   32'd0);
    check("rst_wr_addr", 32'(bus.o_wr_addr), 32'd0);
    check("rst_wr_data", bus.o_wr_data,      32'd0);
    check("rst_busy",    32'(bus.o_busy),    32'd0);
    check("rst_done",    32'(bus.o_done),    32'd0);
    check("rst_rdy",     32'(bus.o_rdy),     32'd0);
    check("rst_stall",   32'(bus.o_stall_cnt), 32'd0);

    // 1) K=4, base=1, continuous valid
    clear_logs();
    start_tile(5'd1, 5'd4, sc);
    check("t1_busy", 32'(bus.o_busy), 32'd1);
    check("t1_rdy",  32'(bus.o_rdy),  32'd1);
    for (int t = 0; t < 4; t++) send_vec(t);
    wait_done("t1");
    compare_writes("t1", t1_exp, 7, -1, 0);
    check("t1_idle_busy", 32'(bus.o_busy), 32'd0);
    check("t1_stall", 32'(bus.o_stall_cnt), 32'd0);

    // 2) same data, 3 idle cycles between vectors 1 and 2
    clear_logs();
    start_tile(5'd1, 5'd4, sc);
    send_vec(0);
    send_vec(1);
    repeat (3) @(posedge clk);
    #1;
    send_vec(2);
    send_vec(3);
    wait_done("t2");
    compare_writes("t2", t1_exp, 7, 2, 3);
    check("t2_stall", 32'(bus.o_stall_cnt), 32'(STALL_EXP));

    // 3) address wrap from base 30
    clear_logs();
    start_tile(5'd30, 5'd4, sc);
    for (int t = 0; t < 4; t++) send_vec(t);
    wait_done("t3");
    compare_writes("t3", t3_exp, 7, -1, 0);

    // 4a) K=0: straight to DONE, no writes, never ready
    clear_logs();
    start_tile(5'd5, 5'd0, sc);
    wait_done("t4a");
    check("t4a_writes", 32'(wr_log.size()), 32'd0);
    check("t4a_rdy_cycles", 32'(rdy_cnt), 32'd0);
    check("t4a_done_pulses", 32'(done_log.size()), 32'd1);
    if (done_log.size() > 0) check("t4a_done_timing", 32'(done_log[0]), 32'(sc + 1));

    // 4b) start held high with other arguments during LOAD is ignored
    clear_logs();
    start_tile(5'd2, 5'd2, sc);
    bus.i_start     = 1'b1;
    bus.i_base_addr = 5'd10;
    bus.i_num_vec   = 5'd5;
    send_vec(0);
    send_vec(1);
    bus.i_start = 1'b0;
    wait_done("t4b");
    compare_writes("t4b", t4_exp, 5, -1, 0);

    // 5) reset after 2 of 4 vectors, then K=1 with no stale lane data
    clear_logs();
    start_tile(5'd1, 5'd4, sc);
    send_vec(0);
    send_vec(1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_rst_wr_en", 32'(bus.o_wr_en), 32'd0);
    check("t5_rst_busy",  32'(bus.o_busy),  32'd0);
    check("t5_rst_done",  32'(bus.o_done),  32'd0);
    rst = 1'b0;
    clear_logs();
    repeat (6) @(posedge clk);
    #1;
    check("t5_no_writes_after_rst", 32'(wr_log.size()), 32'd0);
    check("t5_no_done_after_rst",   32'(done_log.size()), 32'd0);
    start_tile(5'd0, 5'd1, sc);
    send_vec(0);
    wait_done("t5");
    compare_writes("t5", t5_exp, 4, -1, 0);

    // 6) back-to-back: start in the done cycle is ignored, start in the next is taken
    clear_logs();
    start_tile(5'd1, 5'd4, sc);
    for (int t = 0; t < 4; t++) send_vec(t);
    n = 0;
    while (!bus.o_done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("t6_first_done_seen", 32'(bus.o_done), 32'd1);
    bus.i_start     = 1'b1;
    bus.i_base_addr = 5'd20;
    bus.i_num_vec   = 5'd1;
    @(posedge clk); #1;
    bus.i_base_addr = 5'd8;
    bus.i_num_vec   = 5'd2;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    clear_logs();
    check("t6_busy_after_start", 32'(bus.o_busy), 32'd1);
    send_vec(0);
    send_vec(1);
    wait_done("t6");
    compare_writes("t6", t6_exp, 5, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
